// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a
// four-state controller that raises a maskable interrupt when the count expires.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;

  logic ctrl_wr;
  logic preset_wr;
  logic en;
  logic auto_reload;
  logic cnt_done;
  logic unused_addr_bits;

  assign ctrl_wr          = we && (addr[1:0] == 2'b00);
  assign preset_wr        = we && (addr[1:0] == 2'b01);
  assign en               = ctrl_q[0];
  assign auto_reload      = (ctrl_q[2:1] == 2'b01);
  assign cnt_done         = (count_q <= 32'd1);
  assign unused_addr_bits = ^addr[29:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    state_d = CNT;
      CNT: begin
        if (!en)          state_d = IDLE;
        else if (cnt_done) state_d = INT;
      end
      INT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register and datapath updates driven by the current state
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    // A CTRL write in the same cycle overrides the one-shot EN clear.
    if (state_q == INT && !auto_reload) ctrl_d[0] = 1'b0;
    if (ctrl_wr)   ctrl_d   = din[3:0];
    if (preset_wr) preset_d = din;

    case (state_q)
      LOAD:    count_d = preset_q;
      CNT:     if (en) count_d = cnt_done ? 32'd0 : count_q - 32'd1;
      default: count_d = count_q;
    endcase

    // Flag is raised on the edge that enters INT so irq lines up with that edge.
    if (ctrl_wr) flag_d = 1'b0;
    if (state_q == INT && auto_reload) flag_d = 1'b0;
    if (state_q == CNT && en && cnt_done) flag_d = 1'b1;

    irq_d = flag_d & ctrl_d[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr[1:0])
      2'b00:   dout = {28'd0, ctrl_q};
      2'b01:   dout = preset_q;
      2'b10:   dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// PRESET/MODE/IM runs checked against closed-form timing of COUNT and irq.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected COUNT k edges after the edge that wrote EN=1.
  function automatic logic [31:0] exp_count(int n, int k, bit auto_mode);
    int m = (n < 1) ? 1 : n;
    int p = m + 3;
    int o = auto_mode ? (k % p) : k;
    if (o < 2) return 32'd0;
    if (n - (o - 2) > 0) return 32'(n - (o - 2));
    return 32'd0;
  endfunction

  // Expected irq k edges after the edge that wrote EN=1.
  function automatic bit exp_irq(int n, int k, bit auto_mode, bit im);
    int m = (n < 1) ? 1 : n;
    int p = m + 3;
    if (!im) return 1'b0;
    if (auto_mode) return (k % p) == (m + 2);
    return k >= (m + 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = {28'd0, a};
    din  = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    din  = 32'd0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = {28'd0, a};
    #1;
    v = dout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    step();
    rd(2'd0, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl got=0x%h exp=0x0", v); end
    rd(2'd1, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_preset got=0x%h exp=0x0", v); end
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_count got=0x%h exp=0x0", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      step();
      rd(2'd2, v); checks++;
      if (v !== exp_count(5, k, 1'b0)) begin
        errors++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, v, exp_count(5, k, 1'b0));
      end
      checks++;
      if (irq !== exp_irq(5, k, 1'b0, 1'b1)) begin
        errors++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, exp_irq(5, k, 1'b0, 1'b1));
      end
    end
    rd(2'd0, v); checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got=0x%h exp=0x8", v); end
    wr(2'd0, 32'h8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
    $display("test_oneshot done");
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    int pulses = 0;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (irq === 1'b1) pulses++;
      checks++;
      if (irq !== ((k >= 5) && ((k - 5) % 6 == 0))) begin
        errors++; $display("FAIL auto_irq k=%0d got=%b exp=%b", k, irq, (k >= 5) && ((k - 5) % 6 == 0));
      end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL auto_pulse_count got=%0d exp=3", pulses); end
    rd(2'd0, v); checks++;
    if (v !== 32'hB) begin errors++; $display("FAIL auto_ctrl got=0x%h exp=0xb", v); end
    $display("test_autoreload done");
  endtask

  task automatic test_masked();
    logic [31:0] v;
    int seen = 0;
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (irq !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL masked_irq got=%0d high cycles exp=0", seen); end
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL masked_count got=%0d exp=0", v); end
    rd(2'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL masked_ctrl_en_cleared got=0x%h exp=0x0", v); end
    $display("test_masked done");
  endtask

  task automatic test_freeze_reload();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    step();
    step();
    wr(2'd1, 32'd3);
    step();
    step();
    rd(2'd2, v); checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL freeze_pre got=%0d exp=7", v); end
    wr(2'd0, 32'h0);
    rd(2'd2, v); checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL freeze_at6 got=%0d exp=6", v); end
    step();
    step();
    step();
    rd(2'd2, v); checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL freeze_hold got=%0d exp=6", v); end
    wr(2'd0, 32'h1);
    step();
    step();
    rd(2'd2, v); checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL freeze_reload got=%0d exp=3", v); end
    $display("test_freeze_reload done");
  endtask

  task automatic test_ctrl_priority();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq_pre got=%b exp=1", irq); end
    wr(2'd0, 32'h9);
    rd(2'd0, v); checks++;
    if (v !== 32'h9) begin errors++; $display("FAIL prio_ctrl got=0x%h exp=0x9", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL prio_irq_clear got=%b exp=0", irq); end
    step();
    step();
    rd(2'd2, v); checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL prio_restart got=%0d exp=2", v); end
    $display("test_ctrl_priority done");
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    int seen = 0;
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) step();
    rd(2'd2, v); checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL midreset_pre got=%0d exp=4", v); end
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    reset = 1'b0;
    rd(2'd0, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL midreset_ctrl got=0x%h exp=0x0", v); end
    rd(2'd1, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL midreset_preset got=0x%h exp=0x0", v); end
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL midreset_count got=0x%h exp=0x0", v); end
    for (int k = 0; k < 6; k++) begin
      if (irq !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_irq got=%0d high cycles exp=0", seen); end
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL count_readonly got=0x%h exp=0x0", v); end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL addr3_read got=0x%h exp=0x0", v); end
    rd(2'd0, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL addr3_alias_ctrl got=0x%h exp=0x0", v); end
    $display("test_reset_midcount done");
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] ec;
    bit          ei;
    for (int t = 0; t < 10; t++) begin
      int  n    = (t < 2) ? t : int'($urandom_range(0, 12));
      int  mode = int'($urandom_range(0, 3));
      bit  im   = 1'($urandom_range(0, 1));
      bit  am   = (mode == 1);
      int  m    = (n < 1) ? 1 : n;
      int  len  = am ? 3 * (m + 3) : m + 5;
      logic [31:0] ctrl_w = {28'd0, im, 2'(mode), 1'b1};
      logic [31:0] ctrl_e = am ? ctrl_w : {28'd0, im, 2'(mode), 1'b0};
      do_reset();
      wr(2'd1, 32'(n));
      wr(2'd0, ctrl_w);
      for (int k = 1; k <= len; k++) begin
        step();
        ec = exp_count(n, k, am);
        ei = exp_irq(n, k, am, im);
        rd(2'd2, v); checks++;
        if (v !== ec) begin
          errors++; $display("FAIL rand_count t=%0d n=%0d mode=%0d k=%0d got=%0d exp=%0d", t, n, mode, k, v, ec);
        end
        checks++;
        if (irq !== ei) begin
          errors++; $display("FAIL rand_irq t=%0d n=%0d mode=%0d im=%0d k=%0d got=%b exp=%b", t, n, mode, im, k, irq, ei);
        end
      end
      rd(2'd0, v); checks++;
      if (v !== ctrl_e) begin
        errors++; $display("FAIL rand_ctrl t=%0d got=0x%h exp=0x%h", t, v, ctrl_e);
      end
      $display("random trial %0d: preset=%0d mode=%0d im=%0d", t, n, mode, im);
    end
  endtask

  initial begin
    reset = 1'b0;
    addr  = 30'd0;
    we    = 1'b0;
    din   = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_freeze_reload();
    test_ctrl_priority();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have no parameters; register map and widths are fixed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 addr  input  30  word address from the bridge (byte address [31:2]); only addr[1:0] is decoded (00=CTRL, 01=PRESET, 10=COUNT, 11=unused).
REQ-005 we  input  1  write enable from the bridge, valid only for the cycle it is high.
REQ-006 din  input  32  write data.
REQ-007 dout  output  32  read data, combinational from the current register state and addr.
REQ-008 irq  output  1  registered interrupt request, driven to the CPU HWInt line.

Function
REQ-009 CTRL SHALL be bits [3:0]: [0] EN (count enable), [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as 00), [3] IM (interrupt mask, 1 = irq allowed); bits [31:4] SHALL read 0 and ignore writes.
REQ-010 PRESET SHALL be a 32-bit read/write register; a write SHALL NOT disturb a count in progress and SHALL take effect at the next LOAD.
REQ-011 COUNT SHALL be read-only; writes to COUNT or to addr 11 SHALL be ignored, and reads of addr 11 SHALL return 0.
REQ-012 The controller SHALL be a four-state FSM: IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if EN=1, go to LOAD next edge; otherwise stay, COUNT held.
REQ-014 LOAD: COUNT <= PRESET; go to CNT.
REQ-015 CNT: if EN=0, go to IDLE with COUNT held; else if COUNT > 1, COUNT <= COUNT-1; else (COUNT is 0 or 1), COUNT <= 0 and go to INT.
REQ-016 INT: set the interrupt flag; in MODE 00 clear EN; in both modes go to IDLE next edge.
REQ-017 Interrupt flag in MODE 00 SHALL stay set until any CTRL write; in MODE 01 it SHALL clear automatically after one cycle.
REQ-018 irq SHALL equal flag AND IM, registered, with no combinational path from din or we.
REQ-019 With PRESET=N>=2 in MODE 00, irq SHALL rise at the (N+2)th rising edge after the edge that writes EN=1; with N=0 or N=1 it SHALL rise at the 3rd edge.
REQ-020 In MODE 01 with EN held at 1, successive irq pulses SHALL be N+3 cycles apart (N>=2), each exactly one cycle wide.
REQ-021 A CTRL write in the same cycle that INT clears EN SHALL take priority: the written EN value is kept.
REQ-022 Clearing EN during CNT SHALL freeze COUNT; setting EN again SHALL restart through LOAD (COUNT reloaded from PRESET, not resumed).
REQ-023 COUNT arithmetic SHALL be 32-bit unsigned with no wrap below 0.

Reset
REQ-024 Reset SHALL take priority over writes and the FSM: CTRL=0, PRESET=0, COUNT=0, flag=0, irq=0, state=IDLE.
REQ-025 Reset asserted mid-count SHALL abort the count with no irq pulse on the following cycle.

Verification
REQ-026 PRESET=5, CTRL=0x9 (EN, MODE 00, IM) -> COUNT reads 5,4,3,2,1,0; irq rises at the 7th edge after the CTRL write and stays high; CTRL reads 0x8; a write of CTRL=0x8 clears irq the next edge.
REQ-027 PRESET=3, CTRL=0xB (auto-reload) for 20 cycles -> one-cycle irq pulses every 6 cycles; EN stays 1.
REQ-028 CTRL=0x1 (IM=0), PRESET=2 -> COUNT reaches 0, FSM passes INT, irq stays 0 throughout.
REQ-029 During a count with PRESET=10, write PRESET=3, then clear EN at COUNT=6, then set EN -> COUNT freezes at 6, then reloads to 3 (not 10, not 6).
REQ-030 Reset pulse while COUNT=4 -> all reads return 0 on the next cycle and irq=0; write addr 10 with 0xFFFF_FFFF -> COUNT unchanged; read addr 11 -> 0.
